hilo_muldiv_ctrl: RTL and testbench
===================================

# hilo_muldiv_ctrl

Sequencer and owner of the HI/LO register pair for the MIPS core. Accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO requests from the ALU decode stage via `alu_control`, runs multiply and divide as 32-iteration sequential operations, and commits results to HI/LO atomically. Exposes `busy` so the core stalls until the result is committed, and exposes HI/LO to the MFHI/MFLO read path.

## Interface
- `XLEN`, 32: operand and HI/LO width. Only 32 is supported.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; sampled only when `busy`=0.
- `alu_control`  in  5  operation code: MULT=10000, MULTU=10001, DIV=10010, DIVU=10011, MTLO=10101, MTHI=10110. All other codes are ignored.
- `op_a`  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO source.
- `op_b`  in  32  rt operand: multiplier or divisor.
- `busy`  out  1  high while a multiply or divide is in flight.
- `done`  out  1  one-cycle pulse, high in the first cycle the new HI/LO values are visible.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, RUN, COMMIT.
- IDLE, `start`=1, MULT/MULTU/DIV/DIVU:
  - Latch the operation and signedness.
  - For signed operations, latch the operand magnitudes and result sign flags. Take the magnitude as the 32-bit unsigned two's-complement negate, so 0x80000000 maps to 0x80000000.
  - Clear the iteration counter and go to RUN.
- IDLE, `start`=1, MTHI/MTLO: write `op_a` to `hi` or `lo` at that edge. Stay in IDLE. No `done` pulse.
- IDLE, other code or `start`=0: no change.
- RUN, one iteration per cycle, 32 cycles:
  - Multiply: unsigned shift-add into a 64-bit product.
  - Divide: restoring division producing a 32-bit quotient and 32-bit remainder.
  - After the iteration with counter = 31, go to COMMIT.
- COMMIT:
  - Apply the sign fix: the product is negated if the operand signs differ; the quotient is negated if the signs differ; the remainder takes the dividend's sign.
  - Write HI = product[63:32] / remainder and LO = product[31:0] / quotient.
  - Assert `done` and go to IDLE.
- Divide by zero: full latency, HI/LO left unchanged, `done` still pulses.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This is the natural wrap; no trap.
- `start` while `busy`=1 is ignored, including MTHI/MTLO. The core must hold the request until `busy`=0.
- `hi`/`lo` keep their old values throughout RUN, so an MFHI/MFLO issued before the operation reads pre-operation values.

## Timing
- Reset (async assert): state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
- Reset mid-operation aborts the operation. HI/LO are cleared, and no `done` pulse is produced.
- Multiply/divide accepted at edge E:
  - `busy`=1 from after E through the cycle ending at edge E+33.
  - Results are written at edge E+33.
  - `done`=1 and `busy`=0 in the cycle following E+33.
  - A new `start` is accepted in that same cycle.
- MTHI/MTLO accepted at edge E: value visible after E, zero stall cycles.
- `busy` and `done` are registered outputs, not combinational from `start`.

## Structure
- Shared package `mips_pkg`: the 5-bit ALU control encodings (including CONTROL_MULT…CONTROL_MTHI), the state enum, and `XLEN`. The decoder and this block import the same encodings.
- Sub-module `muldiv_iter`: a combinational single-step datapath, one shift-add step or one restore step. The controller owns all state, the counter, and the sign fix.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → at E+34: HI=0xFFFFFFFE, LO=0x00000001, `done` high for exactly 1 cycle, `busy` high for 33 cycles.
- MULT −3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 7 → LO=14, HI=2.
- DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- Divide by zero with HI=0x11, LO=0x22 preloaded → values unchanged and `done` pulses.
- MTHI 0xABCD while `busy` → ignored.
- MTHI after `done` → HI=0xABCD the next cycle.
- Reset asserted at iteration 10 of a DIVU → all outputs 0 immediately, no `done`, and the next MULTU completes normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core encodings: ALU control codes seen by the decoder and the
// HI/LO multiply/divide sequencer, plus the sequencer state encoding.
package mips_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] CONTROL_MULT  = 5'b10000;
    localparam logic [4:0] CONTROL_MULTU = 5'b10001;
    localparam logic [4:0] CONTROL_DIV   = 5'b10010;
    localparam logic [4:0] CONTROL_DIVU  = 5'b10011;
    localparam logic [4:0] CONTROL_MTLO  = 5'b10101;
    localparam logic [4:0] CONTROL_MTHI  = 5'b10110;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_COMMIT = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// One unsigned iteration of shift-add multiply or restoring divide.
// Latency: combinational, no state.
// Backpressure: none; the caller decides when to register acc_nxt.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_nxt
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   r_sh;
    logic [XLEN-1:0] diff;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
    always_comb begin
        sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        r_sh = acc[2*XLEN-1:XLEN-1];
        diff = r_sh[XLEN-1:0] - opnd;
        if (is_div) begin
            if (r_sh >= {1'b0, opnd}) acc_nxt = {diff, acc[XLEN-2:0], 1'b1};
            else                      acc_nxt = {r_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            acc_nxt = {sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: sequences MULT/MULTU/DIV/DIVU and services MTHI/MTLO.
// Latency: mul/div result written 33 edges after accept; MTHI/MTLO at the accept edge.
// Backpressure: busy high while running; start is ignored (not queued) while busy.
module hilo_muldiv_ctrl #(
    parameter int XLEN = mips_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [4:0]      alu_control,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    import mips_pkg::*;

    localparam int CW = $clog2(XLEN);

    muldiv_state_t     state;
    logic              is_div, neg_res, neg_rem, div_zero;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc, acc_nxt;
    logic [CW-1:0]     cnt;

    logic              is_md, is_signed, a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b, quot_fix, rem_fix;
    logic [2*XLEN-1:0] prod_fix;

    // Plain two's-complement negate, so the most negative value maps to itself.
    always_comb begin
        is_md     = (alu_control == CONTROL_MULT) || (alu_control == CONTROL_MULTU) ||
                    (alu_control == CONTROL_DIV)  || (alu_control == CONTROL_DIVU);
        is_signed = (alu_control == CONTROL_MULT) || (alu_control == CONTROL_DIV);
        a_neg     = is_signed & op_a[XLEN-1];
        b_neg     = is_signed & op_b[XLEN-1];
        mag_a     = a_neg ? -op_a : op_a;
        mag_b     = b_neg ? -op_b : op_b;
        prod_fix  = neg_res ? -acc : acc;
        quot_fix  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix   = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    end

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .is_div  (is_div),
        .acc     (acc),
        .opnd    (opnd),
        .acc_nxt (acc_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && is_md) begin
                        is_div   <= alu_control[1];
                        acc      <= {{XLEN{1'b0}}, (alu_control[1] ? mag_a : mag_b)};
                        opnd     <= alu_control[1] ? mag_b : mag_a;
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= alu_control[1] && (op_b == '0);
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end else if (start && alu_control == CONTROL_MTHI) begin
                        hi <= op_a;
                    end else if (start && alu_control == CONTROL_MTLO) begin
                        lo <= op_a;
                    end
                end
                ST_RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(XLEN-1)) state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    // A zero divisor still costs full latency but leaves HI/LO intact.
                    if (!div_zero) begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end else begin
                            hi <= prod_fix[2*XLEN-1:XLEN];
                            lo <= prod_fix[XLEN-1:0];
                        end
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed vectors for hilo_muldiv_ctrl: table of mul/div results plus
// hand sequences for preload, divide by zero, busy-time MTHI and mid-op reset.
module tb_hilo_muldiv_ctrl;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  alu_control = '0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_fail = 0;

    hilo_muldiv_ctrl #(.XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .alu_control (alu_control),
        .op_a        (op_a),
        .op_b        (op_b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op; return at the negedge where done is seen (or after the bound).
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int bcnt, output bit got_done);
        @(negedge clk);
        start = 1'b1; alu_control = op; op_a = a; op_b = b;
        @(posedge clk);
        #1 start = 1'b0; alu_control = '0;
        bcnt = 0;
        got_done = 1'b0;
        for (int i = 0; i < 60 && !got_done; i++) begin
            @(negedge clk);
            if (done) got_done = 1'b1;
            else if (busy) bcnt++;
        end
    endtask

    task automatic move_to(input logic [4:0] op, input logic [31:0] v);
        @(negedge clk);
        start = 1'b1; alu_control = op; op_a = v;
        @(posedge clk);
        #1 start = 1'b0; alu_control = '0;
    endtask

    initial begin
        int  bcnt;
        bit  got;
        int  ndone;

        vecs[0]  = '{CONTROL_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{CONTROL_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{CONTROL_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{CONTROL_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[4]  = '{CONTROL_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{CONTROL_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[6]  = '{CONTROL_MULT,  32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
        vecs[7]  = '{CONTROL_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{CONTROL_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
        vecs[9]  = '{CONTROL_DIVU,  32'd5,        32'd10,       32'd5,        32'd0};
        vecs[10] = '{CONTROL_MULTU, 32'h00010000, 32'h00010000, 32'd1,        32'd0};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, bcnt, got);
            check($sformatf("vec%0d done seen", i), got, 1);
            check($sformatf("vec%0d busy cycles", i), bcnt, 33);
            check($sformatf("vec%0d busy at done", i), busy, 0);
            check($sformatf("vec%0d hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d lo", i), lo, vecs[i].lo);
            @(negedge clk);
            check($sformatf("vec%0d done width", i), done, 0);
        end

        // Preload via MTHI/MTLO, zero-stall visibility, then divide by zero
        move_to(CONTROL_MTHI, 32'h11);
        check("mthi visible", hi, 32'h11);
        check("mthi no busy", busy, 0);
        check("mthi no done", done, 0);
        move_to(CONTROL_MTLO, 32'h22);
        check("mtlo visible", lo, 32'h22);
        do_op(CONTROL_DIV, 32'd1234, 32'd0, bcnt, got);
        check("div0 done", got, 1);
        check("div0 busy cycles", bcnt, 33);
        check("div0 hi kept", hi, 32'h11);
        check("div0 lo kept", lo, 32'h22);

        // MTHI while busy is dropped; HI/LO hold old values during RUN
        @(negedge clk);
        start = 1'b1; alu_control = CONTROL_MULTU; op_a = 32'd3; op_b = 32'd4;
        @(posedge clk);
        #1 start = 1'b0; alu_control = '0;
        repeat (5) @(negedge clk);
        start = 1'b1; alu_control = CONTROL_MTHI; op_a = 32'hABCD;
        @(posedge clk);
        #1 start = 1'b0; alu_control = '0;
        check("busy hi old", hi, 32'h11);
        check("busy lo old", lo, 32'h22);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check("mul busy done", got, 1);
        check("mthi ignored hi", hi, 32'd0);
        check("mul 3x4 lo", lo, 32'd12);

        // MTHI in the done cycle is accepted
        start = 1'b1; alu_control = CONTROL_MTHI; op_a = 32'hABCD;
        @(posedge clk);
        #1 start = 1'b0; alu_control = '0;
        check("mthi after done", hi, 32'hABCD);
        check("mthi after done busy", busy, 0);

        // Reset at iteration 10 of a DIVU
        @(negedge clk);
        start = 1'b1; alu_control = CONTROL_DIVU; op_a = 32'd1000; op_b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0; alu_control = '0;
        repeat (10) @(negedge clk);
        check("pre-reset busy", busy, 1);
        reset = 1'b0;
        #1;
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset hi", hi, 0);
        check("midreset lo", lo, 0);
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("no done after reset", ndone, 0);
        do_op(CONTROL_MULTU, 32'd6, 32'd7, bcnt, got);
        check("post-reset done", got, 1);
        check("post-reset busy cycles", bcnt, 33);
        check("post-reset hi", hi, 0);
        check("post-reset lo", lo, 32'd42);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
